// File: rtl/axi_fft_master_pkg.sv
// Shared types and constants for the FFT subsystem AXI burst master.
package axi_fft_master_pkg;

    localparam int unsigned ADDR_WIDTH   = 12;
    localparam int unsigned LEN_WIDTH    = 8;
    localparam int unsigned SAMPLE_WIDTH = 16;
    localparam int unsigned STRB_WIDTH   = 2;

    localparam logic [1:0]            AXI_BURST_INCR = 2'b01;
    localparam logic [2:0]            AXI_SIZE_2B    = 3'b001;
    localparam logic [STRB_WIDTH-1:0] AXI_WSTRB_ALL  = STRB_WIDTH'(2'b11);

    typedef enum logic [2:0] {
        M_IDLE,
        M_AW,
        M_W,
        M_B,
        M_AR,
        M_R,
        M_DONE
    } master_state_e;

    // Beat counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
        return (v == {LEN_WIDTH{1'b1}}) ? v : v + LEN_WIDTH'(1);
    endfunction

endpackage

// File: rtl/axi_fft_master.sv
// AXI4 initiator: writes one sample frame as an INCR burst, then reads the
// FFT results back with a single read burst and streams them to a sink.
module axi_fft_master
    import axi_fft_master_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_W_WIDTH = 2,
    parameter int unsigned ID_R_WIDTH = 2,
    parameter int unsigned W_ID       = 0,
    parameter int unsigned R_ID       = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_START,
    input  logic [ADDR_WIDTH-1:0]   i_BASE_ADDR,
    input  logic [LEN_WIDTH-1:0]    i_LEN,
    input  logic [SAMPLE_WIDTH-1:0] i_SAMPLE,
    input  logic                    i_SAMPLE_VALID,
    output logic                    o_SAMPLE_READY,
    output logic [DATA_WIDTH-1:0]   o_RESULT,
    output logic                    o_RESULT_VALID,
    output logic                    o_RESULT_LAST,
    output logic                    o_BUSY,
    output logic                    o_DONE,
    output logic                    o_ERR,
    output logic [ADDR_WIDTH-1:0]   o_AWADDR,
    output logic [LEN_WIDTH-1:0]    o_AWLEN,
    output logic [2:0]              o_AWSIZE,
    output logic [1:0]              o_AWBURST,
    output logic [ID_W_WIDTH-1:0]   o_AWID,
    output logic                    o_AWVALID,
    input  logic                    i_AWREADY,
    output logic [SAMPLE_WIDTH-1:0] o_WDATA,
    output logic [STRB_WIDTH-1:0]   o_WSTRB,
    output logic                    o_WLAST,
    output logic                    o_WVALID,
    input  logic                    i_WREADY,
    input  logic                    i_BVALID,
    input  logic [ID_W_WIDTH-1:0]   i_BID,
    output logic                    o_BREADY,
    output logic [ADDR_WIDTH-1:0]   o_ARADDR,
    output logic [LEN_WIDTH-1:0]    o_ARLEN,
    output logic [2:0]              o_ARSIZE,
    output logic [1:0]              o_ARBURST,
    output logic [ID_R_WIDTH-1:0]   o_ARID,
    output logic                    o_ARVALID,
    input  logic                    i_ARREADY,
    input  logic [DATA_WIDTH-1:0]   i_RDATA,
    input  logic [ID_R_WIDTH-1:0]   i_RID,
    input  logic                    i_RVALID,
    input  logic                    i_RLAST,
    output logic                    o_RREADY
);

    master_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, cnt_at_len;

    assign aw_hs      = (state_q == M_AW) && i_AWREADY;
    assign w_hs       = (state_q == M_W)  && i_SAMPLE_VALID && i_WREADY;
    assign b_hs       = (state_q == M_B)  && i_BVALID;
    assign ar_hs      = (state_q == M_AR) && i_ARREADY;
    assign r_hs       = (state_q == M_R)  && i_RVALID;
    assign cnt_at_len = (cnt_q == len_q);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= M_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            M_IDLE: if (i_START)            state_d = M_AW;
            M_AW:   if (aw_hs)              state_d = M_W;
            M_W:    if (w_hs && cnt_at_len) state_d = M_B;
            M_B:    if (b_hs)               state_d = M_AR;
            M_AR:   if (ar_hs)              state_d = M_R;
            M_R:    if (r_hs && i_RLAST)    state_d = M_DONE;
            M_DONE:                         state_d = M_IDLE;
            default:                        state_d = M_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            addr_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // Burst parameters, beat counter and sticky protocol error.
    always_comb begin
        addr_d = addr_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        unique case (state_q)
            M_IDLE: begin
                if (i_START) begin
                    addr_d = i_BASE_ADDR;
                    len_d  = i_LEN;
                    cnt_d  = '0;
                    err_d  = 1'b0;
                end
            end
            M_W: begin
                if (w_hs) cnt_d = sat_inc(cnt_q);
            end
            M_B: begin
                if (b_hs && (i_BID != ID_W_WIDTH'(W_ID))) err_d = 1'b1;
            end
            M_AR: begin
                if (ar_hs) cnt_d = '0;
            end
            M_R: begin
                if (r_hs) begin
                    cnt_d = sat_inc(cnt_q);
                    if (i_RID != ID_R_WIDTH'(R_ID)) err_d = 1'b1;
                    if (i_RLAST && !cnt_at_len)     err_d = 1'b1;
                    // Beat at or beyond the final index that is not flagged last.
                    if (!i_RLAST && (cnt_q >= len_q)) err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Channel outputs; W and R payloads pass straight through in their phase.
    always_comb begin
        o_SAMPLE_READY = 1'b0;
        o_RESULT       = '0;
        o_RESULT_VALID = 1'b0;
        o_RESULT_LAST  = 1'b0;
        o_BUSY         = (state_q != M_IDLE);
        o_DONE         = (state_q == M_DONE);
        o_ERR          = err_q;
        o_AWADDR       = addr_q;
        o_AWLEN        = len_q;
        o_AWSIZE       = '0;
        o_AWBURST      = '0;
        o_AWID         = ID_W_WIDTH'(W_ID);
        o_AWVALID      = 1'b0;
        o_WDATA        = '0;
        o_WSTRB        = '0;
        o_WLAST        = 1'b0;
        o_WVALID       = 1'b0;
        o_BREADY       = 1'b0;
        o_ARADDR       = addr_q;
        o_ARLEN        = len_q;
        o_ARSIZE       = '0;
        o_ARBURST      = '0;
        o_ARID         = ID_R_WIDTH'(R_ID);
        o_ARVALID      = 1'b0;
        o_RREADY       = 1'b0;

        if (state_q != M_IDLE) begin
            o_AWSIZE  = AXI_SIZE_2B;
            o_AWBURST = AXI_BURST_INCR;
            o_ARSIZE  = AXI_SIZE_2B;
            o_ARBURST = AXI_BURST_INCR;
            o_WSTRB   = AXI_WSTRB_ALL;
        end

        unique case (state_q)
            M_AW: o_AWVALID = 1'b1;
            M_W: begin
                o_WVALID       = i_SAMPLE_VALID;
                o_WDATA        = i_SAMPLE;
                o_SAMPLE_READY = i_WREADY;
                o_WLAST        = cnt_at_len && i_SAMPLE_VALID;
            end
            M_B:  o_BREADY  = 1'b1;
            M_AR: o_ARVALID = 1'b1;
            M_R: begin
                o_RREADY       = 1'b1;
                o_RESULT       = i_RDATA;
                o_RESULT_VALID = i_RVALID;
                o_RESULT_LAST  = i_RVALID && i_RLAST;
            end
            default: ;
        endcase
    end

endmodule
